// File: rtl/rc_pkg.sv
// Shared definitions for the RC PWM decoder: default timing constants,
// per-channel capture FSM encoding and the width-to-throttle mapping.
package rc_pkg;

  localparam int DEF_CLKS_PER_US  = 50;
  localparam int DEF_MIN_PULSE_US = 800;
  localparam int DEF_MAX_PULSE_US = 2500;
  localparam int DEF_TIMEOUT_US   = 25000;

  // Pulse widths are carried as 12-bit microsecond counts.
  localparam int US_W = 12;

  // Throttle mapping bounds in microseconds.
  localparam logic [US_W-1:0] THR_LO_US = 12'd1000;
  localparam logic [US_W-1:0] THR_HI_US = 12'd2020;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    OVERLONG  = 2'd2
  } chan_state_e;

  // Width of a divide-by-clks prescaler (at least one bit).
  function automatic int pre_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

  // Accepted width -> throttle: clamp below 1000 us and at/above 2020 us,
  // otherwise one throttle step per 4 us.
  function automatic logic [7:0] throttle_map(input logic [US_W-1:0] w);
    if (w <= THR_LO_US) return 8'd0;
    if (w >= THR_HI_US) return 8'd255;
    return 8'((w - THR_LO_US) >> 2);
  endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// One RC PWM channel: input synchronizer, edge detect, capture FSM,
// microsecond prescaler/counter, throttle mapping and (with
// RC_FAILSAFE_EN defined) a silence counter driving signal_lost.
module pwm_capture_channel
  import rc_pkg::*;
#(
  parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
`ifdef RC_FAILSAFE_EN
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US
`else
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rc_line,
`ifdef RC_FAILSAFE_EN
  input  logic            us_tick,
`endif
  output logic [7:0]      throttle,
  output logic [US_W-1:0] pulse_width,
  output logic            valid,
  output logic            signal_lost
);

  localparam int                PRE_W    = pre_width(CLKS_PER_US);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0]   MIN_W    = US_W'(MIN_PULSE_US);
  localparam logic [US_W-1:0]   MAX_W    = US_W'(MAX_PULSE_US);

  logic meta_q, sync_q, sync_d_q;
  logic rise, fall;

  chan_state_e state_q, state_d;
  logic        accept;

  logic [PRE_W-1:0] pre_q;
  logic [US_W-1:0]  us_q, us_inc;
  logic             pre_wrap;

  logic [7:0]       throttle_q;
  logic [US_W-1:0]  pulse_width_q;
  logic             valid_q, lost_q;

  // Two-flop synchronizer plus delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      // Reset to 1 so a line already high at release never looks like a rise.
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      sync_d_q <= 1'b1;
    end else begin
      meta_q   <= rc_line;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d_q;
  assign fall = ~sync_q & sync_d_q;

  // The interval runs edge to edge, so a tick landing in the fall cycle counts.
  assign pre_wrap = (pre_q == PRE_LAST);
  assign us_inc   = us_q + {{(US_W-1){1'b0}}, pre_wrap};

  // Capture FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= WAIT_RISE;
    else       state_q <= state_d;
  end

  // Capture FSM next state and acceptance decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      WAIT_RISE: if (rise) state_d = HIGH;
      HIGH: begin
        if (fall) begin
          state_d = WAIT_RISE;
          accept  = (us_inc >= MIN_W) && (us_inc <= MAX_W);
        end else if (us_inc > MAX_W) begin
          state_d = OVERLONG;
        end
      end
      OVERLONG:  if (fall) state_d = WAIT_RISE;
      default:   state_d = WAIT_RISE;
    endcase
  end

  // Cycle prescaler and microsecond counter, restarted on each rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (state_q == WAIT_RISE && rise) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (state_q == HIGH) begin
      pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
      us_q  <= us_inc;
    end
  end

`ifdef RC_FAILSAFE_EN
  localparam int               SIL_W   = $clog2(TIMEOUT_US + 1);
  localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(TIMEOUT_US);

  logic [SIL_W-1:0] silence_q;
  logic             timeout_hit;

  assign timeout_hit = us_tick && (silence_q == SIL_MAX - 1'b1);

  // Silence counter: microseconds since the last accepted pulse, saturating.
  always_ff @(posedge clock) begin
    if (reset)                                  silence_q <= '0;
    else if (accept)                            silence_q <= '0;
    else if (us_tick && silence_q != SIL_MAX)   silence_q <= silence_q + 1'b1;
  end
`endif

  // Output registers: updated only on acceptance (or failsafe timeout).
  always_ff @(posedge clock) begin
    if (reset) begin
      throttle_q    <= '0;
      pulse_width_q <= '0;
      valid_q       <= 1'b0;
      lost_q        <= 1'b1;
    end else begin
      valid_q <= accept;
      if (accept) begin
        pulse_width_q <= us_inc;
        throttle_q    <= throttle_map(us_inc);
      end
`ifdef RC_FAILSAFE_EN
      if (accept) begin
        lost_q <= 1'b0;
      end else if (timeout_hit) begin
        lost_q     <= 1'b1;
        throttle_q <= '0;
      end
`else
      lost_q <= 1'b0;
`endif
    end
  end

  assign throttle    = throttle_q;
  assign pulse_width = pulse_width_q;
  assign valid       = valid_q;
  assign signal_lost = lost_q;

endmodule

// File: rtl/rc_pwm_decoder.sv
// Four-channel RC receiver PWM decoder. Define RC_FAILSAFE_EN to enable
// per-channel loss detection (signal_lost and throttle forced to 0 after
// TIMEOUT_US of silence). Channel 1 is rc_in[3], channel 4 is rc_in[0].
module rc_pwm_decoder
  import rc_pkg::*;
#(
  parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  rc_in,
  output logic [7:0]  throttle1,
  output logic [7:0]  throttle2,
  output logic [7:0]  throttle3,
  output logic [7:0]  throttle4,
  output logic [47:0] pulse_width,
  output logic [3:0]  valid,
  output logic [3:0]  signal_lost
);

  // Widths must fit the 12-bit per-channel field.
  if (MIN_PULSE_US > MAX_PULSE_US || MAX_PULSE_US >= (1 << US_W) ||
      TIMEOUT_US < 1 || CLKS_PER_US < 1) begin : g_bad_params
    $error("rc_pwm_decoder: inconsistent timing parameters");
  end

  logic [7:0] thr [4];

`ifdef RC_FAILSAFE_EN
  localparam int               PRE_W    = pre_width(CLKS_PER_US);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);

  logic [PRE_W-1:0] tick_pre_q;
  logic             us_tick;

  assign us_tick = (tick_pre_q == PRE_LAST);

  // Free-running 1 us tick shared by all silence counters.
  always_ff @(posedge clock) begin
    if (reset) tick_pre_q <= '0;
    else       tick_pre_q <= us_tick ? '0 : tick_pre_q + 1'b1;
  end
`endif

  for (genvar i = 0; i < 4; i++) begin : g_chan
    pwm_capture_channel #(
      .CLKS_PER_US  (CLKS_PER_US),
      .MIN_PULSE_US (MIN_PULSE_US),
`ifdef RC_FAILSAFE_EN
      .MAX_PULSE_US (MAX_PULSE_US),
      .TIMEOUT_US   (TIMEOUT_US)
`else
      .MAX_PULSE_US (MAX_PULSE_US)
`endif
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .rc_line     (rc_in[i]),
`ifdef RC_FAILSAFE_EN
      .us_tick     (us_tick),
`endif
      .throttle    (thr[i]),
      .pulse_width (pulse_width[US_W*i +: US_W]),
      .valid       (valid[i]),
      .signal_lost (signal_lost[i])
    );
  end

  assign throttle1 = thr[3];
  assign throttle2 = thr[2];
  assign throttle3 = thr[1];
  assign throttle4 = thr[0];

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Scoreboard bench for rc_pwm_decoder: stimulus pushes the expected
// (channel, width, throttle) of each pulse that must be accepted; a monitor
// pops and compares on every valid strobe. Honours RC_FAILSAFE_EN.
module tb_rc_pwm_decoder;

`ifdef RC_FAILSAFE_EN
  localparam int C = 1;
`else
  localparam int C = 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rc_in = 4'b0000;
  logic [7:0]  throttle1, throttle2, throttle3, throttle4;
  logic [47:0] pulse_width;
  logic [3:0]  valid, signal_lost;

  rc_pwm_decoder #(
    .CLKS_PER_US  (C),
    .MIN_PULSE_US (800),
    .MAX_PULSE_US (2500),
    .TIMEOUT_US   (25000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rc_in       (rc_in),
    .throttle1   (throttle1),
    .throttle2   (throttle2),
    .throttle3   (throttle3),
    .throttle4   (throttle4),
    .pulse_width (pulse_width),
    .valid       (valid),
    .signal_lost (signal_lost)
  );

  always #5 clock = ~clock;

  typedef struct {
    int bit_idx;
    int width;
    int thr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [7:0] thr_of(input int b);
    case (b)
      3:       return throttle1;
      2:       return throttle2;
      1:       return throttle3;
      default: return throttle4;
    endcase
  endfunction

  function automatic logic [11:0] pw_of(input int b);
    return pulse_width[12*b +: 12];
  endfunction

  task automatic wait_us(input int us);
    repeat (us * C) @(negedge clock);
  endtask

  // Drive a high pulse of exactly w_us on rc_in[b]; queue it if it must be accepted.
  task automatic pulse(input int b, input int w_us, input bit accepted, input int thr);
    exp_t e;
    @(negedge clock);
    rc_in[b] = 1'b1;
    wait_us(w_us);
    rc_in[b] = 1'b0;
    if (accepted) begin
      e.bit_idx = b;
      e.width   = w_us;
      e.thr     = thr;
      sb.push_back(e);
    end
    wait_us(50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_throttle1"}, 48'(throttle1), 48'd0);
    check({tag, "_throttle2"}, 48'(throttle2), 48'd0);
    check({tag, "_throttle3"}, 48'(throttle3), 48'd0);
    check({tag, "_throttle4"}, 48'(throttle4), 48'd0);
    check({tag, "_pulse_width"}, pulse_width, 48'd0);
    check({tag, "_valid"}, 48'(valid), 48'd0);
    check({tag, "_signal_lost"}, 48'(signal_lost), 48'hF);
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int c = 0; c < 4; c++) begin
        if (valid[c]) begin
          if (sb.size() == 0) begin
            check($sformatf("unexpected_valid_bit%0d", c), 48'(valid[c]), 48'd0);
          end else begin
            e = sb.pop_front();
            check("sb_channel", 48'(c), 48'(e.bit_idx));
            check($sformatf("sb_width_bit%0d", c), 48'(pw_of(c)), 48'(e.width));
            check($sformatf("sb_throttle_bit%0d", c), 48'(thr_of(c)), 48'(e.thr));
          end
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (5) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_us(5);
`ifdef RC_FAILSAFE_EN
    check("post_reset_lost", 48'(signal_lost), 48'hF);
`else
    check("post_reset_lost", 48'(signal_lost), 48'h0);
`endif

    // Channel 1: nominal pulse.
    pulse(3, 1500, 1'b1, 125);

    // Channel 2: clamp ends and acceptance bounds.
    pulse(2, 1000, 1'b1, 0);
    pulse(2, 2100, 1'b1, 255);
    pulse(2, 800,  1'b1, 0);
    pulse(2, 2500, 1'b1, 255);
    pulse(2, 799,  1'b0, 0);
    check("ch2_short_keeps_width", 48'(pw_of(2)), 48'd2500);
    check("ch2_short_keeps_thr", 48'(throttle2), 48'd255);
    pulse(2, 2019, 1'b1, 254);

    // Channel 3: short pulse discarded after a good one.
    pulse(3 - 2, 1200, 1'b1, 50);
    pulse(1, 500, 1'b0, 0);
    check("ch3_keeps_thr", 48'(throttle3), 48'd50);
    check("ch3_keeps_width", 48'(pw_of(1)), 48'd1200);

    // Channel 4: overlong pulse, then a good one.
    pulse(0, 3000, 1'b0, 0);
    check("ch4_overlong_width", 48'(pw_of(0)), 48'd0);
    check("ch4_overlong_thr", 48'(throttle4), 48'd0);
    pulse(0, 1800, 1'b1, 200);
    check("ch1_held", 48'(throttle1), 48'd125);

    // Reset 700 us into a channel 1 pulse abandons it.
    @(negedge clock);
    rc_in[3] = 1'b1;
    wait_us(700);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check_reset_outputs("midpulse_reset");
    reset = 1'b0;
    repeat (800 * C - 10) @(negedge clock);
    rc_in[3] = 1'b0;
    wait_us(50);
    check("abandoned_width", 48'(pw_of(3)), 48'd0);
    check("abandoned_thr", 48'(throttle1), 48'd0);
    pulse(3, 1500, 1'b1, 125);

`ifdef RC_FAILSAFE_EN
    // Failsafe: silence on channel 1 until it is declared lost.
    pulse(3, 1600, 1'b1, 150);
    pulse(3, 1600, 1'b1, 150);
    check("fs_before_lost", 48'(signal_lost[3]), 48'd0);
    wait_us(24900);
    check("fs_not_yet_lost", 48'(signal_lost[3]), 48'd0);
    check("fs_not_yet_thr", 48'(throttle1), 48'd150);
    wait_us(200);
    check("fs_lost", 48'(signal_lost[3]), 48'd1);
    check("fs_lost_thr", 48'(throttle1), 48'd0);
    pulse(3, 1600, 1'b1, 150);
    check("fs_recovered", 48'(signal_lost[3]), 48'd0);
    check("fs_recovered_thr", 48'(throttle1), 48'd150);
`endif

    wait_us(20);
    check("sb_drained", 48'(sb.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rc_pwm_decoder.md
RC_PWM_DECODER -- requirements
Module: rc_pwm_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_US, 50, clock cycles per microsecond (50 MHz clock).
REQ-002 SHALL have parameter MIN_PULSE_US, 800, shortest accepted high time in us.
REQ-003 SHALL have parameter MAX_PULSE_US, 2500, longest accepted high time in us.
REQ-004 SHALL have parameter TIMEOUT_US, 25000, us without an accepted pulse before a channel is declared lost.
REQ-005 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rc_in  input  4  asynchronous RC receiver PWM lines; bit 3 = channel 1, bit 0 = channel 4.
REQ-008 SHALL have ports throttle1..throttle4  output  8 each  decoded throttle per channel.
REQ-009 SHALL have port pulse_width  output  48  last accepted high time in us, 12 bits per channel; [47:36] = ch1 ... [11:0] = ch4.
REQ-010 SHALL have port valid  output  4  one-cycle strobe per channel on each accepted pulse; bit order as rc_in.
REQ-011 SHALL have port signal_lost  output  4  per-channel lost flag; bit order as rc_in.

Function
REQ-012 SHALL pass each rc_in bit through a two-flop synchronizer; edge detection uses the synchronized value and its one-cycle-delayed copy.
REQ-013 SHALL run per-channel FSM states WAIT_RISE, HIGH, OVERLONG; reset state WAIT_RISE.
REQ-014 SHALL transition WAIT_RISE->HIGH on synchronized rising edge, clearing the channel's cycle prescaler and us counter that cycle.
REQ-015 SHALL in HIGH increment the us counter each time the channel prescaler wraps from CLKS_PER_US-1 to 0; partial microseconds truncate.
REQ-016 SHALL on falling edge in HIGH: if MIN_PULSE_US <= count <= MAX_PULSE_US, accept; else discard; either way return to WAIT_RISE.
REQ-017 SHALL transition HIGH->OVERLONG when count exceeds MAX_PULSE_US; OVERLONG->WAIT_RISE on falling edge; no acceptance from OVERLONG.
REQ-018 SHALL on acceptance update pulse_width, throttle and pulse valid for exactly one cycle, all on the clock edge after the cycle in which the falling edge is detected (<= 4 clocks after raw rc_in falls).
REQ-019 SHALL map accepted width w to throttle: w <= 1000 -> 0; w >= 2020 -> 255; else (w - 1000) >> 2.
REQ-020 SHALL hold throttle and pulse_width between acceptances; discarded pulses change no output.
REQ-021 SHALL keep a per-channel silence counter advancing on a free-running global 1 us tick, cleared on acceptance, saturating at TIMEOUT_US.
REQ-022 SHALL treat a rising edge arriving in the same cycle as a falling-edge acceptance as impossible (synchronizer enforces one edge per cycle); no special case required.

Reset
REQ-023 SHALL on reset drive throttle1..4 = 0, pulse_width = 0, valid = 0, signal_lost = 4'b1111, all FSMs WAIT_RISE, all counters 0.
REQ-024 SHALL on reset asserted mid-pulse abandon the pulse; a pulse already high when reset releases is not measured (no rising edge seen).

Configuration
REQ-025 SHALL with RC_FAILSAFE_EN defined: set signal_lost for a channel when its silence counter reaches TIMEOUT_US, and force that channel's throttle to 0 the same cycle; clear signal_lost on the next acceptance.
REQ-026 SHALL with RC_FAILSAFE_EN undefined: omit silence counters, drive signal_lost = 0 after reset deassertion, hold last throttle indefinitely.

Structure
REQ-027 SHALL place default timing constants, the FSM state encoding and the throttle mapping bounds (1000, 2020) in the shared package rc_pkg.
REQ-028 SHALL instantiate sub-module pwm_capture_channel four times (synchronizer, FSM, prescaler, counters, mapping); top holds only the global us tick and output packing.

Verification
REQ-029 SHALL cover: reset, then 1500 us high pulse on ch1 -> valid[3] strobe once, pulse_width[47:36] = 1500, throttle1 = 125.
REQ-030 SHALL cover: 1000 us and 2100 us pulses on ch2 -> throttle2 = 0 then 255; pulse_width[35:24] = 1000 then 2100.
REQ-031 SHALL cover: 500 us pulse on ch3 after a 1200 us pulse -> no valid, throttle3 stays 50, pulse_width[23:12] stays 1200.
REQ-032 SHALL cover: ch4 held high 3000 us -> OVERLONG, no valid at fall; next 1800 us pulse -> throttle4 = 200.
REQ-033 SHALL cover (RC_FAILSAFE_EN): ch1 at 1600 us pulses then silent 25000 us -> signal_lost[3] = 1, throttle1 = 0; next 1600 us pulse -> signal_lost[3] = 0, throttle1 = 150.
REQ-034 SHALL cover: reset asserted 700 us into a 1500 us pulse -> all outputs at reset values, no valid for that pulse; next full pulse decodes normally.
